// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter FSM states, digit width and counter sizing.
// Also imported by the adder-side modules of the BCD arithmetic chain.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    // Bits needed to hold a shift count running from bin_w down to 0.
    function automatic int cnt_width(input int bin_w);
        return (bin_w < 1) ? 1 : $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One digit of the shift-add-3 correction: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Pre-shift correction, 4-bit wrap is intended (inputs are 0..9).
    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(5)) begin
            dout = din + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble), one bit per clock.
// Digits beyond DIGITS are dropped; any bit carried out of the top digit sets
// a sticky overflow, so bcd_out is the value mod 10^DIGITS.
// The result is copied into dedicated output registers on the last shift,
// so bcd_out/overflow do not churn while a conversion is running.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    bcd_state_t        state;
    bcd_state_t        state_nxt;
    logic [BIN_W-1:0]  bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BCD_W-1:0]  bcd_res_q;
    logic              ovf_res_q;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shift;
    logic              ovf_bit;
    logic              accept;
    logic              last_shift;

    assign accept     = (state == IDLE) && in_valid;
    assign last_shift = (state == SHIFT) && (cnt_q == CNT_W'(1));

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_dabble_digit u_digit (
                .din  (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // {corrected BCD, binary} shifted left by one; the top BCD bit falls out.
    assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign ovf_bit   = bcd_adj[BCD_W-1];

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load, shift-add-3 iteration, sticky overflow and result capture.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd_res_q <= '0;
            ovf_res_q <= 1'b0;
        end else if (accept) begin
            bin_q <= bin_in;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= CNT_W'(BIN_W);
        end else if (state == SHIFT) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_shift;
            ovf_q <= ovf_q | ovf_bit;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_shift) begin
                bcd_res_q <= bcd_shift;
                ovf_res_q <= ovf_q | ovf_bit;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign bcd_out   = bcd_res_q;
    assign overflow  = ovf_res_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed cases, a narrow (BIN_W=10, DIGITS=3)
// instance for overflow, reset abort, backpressure and random values
// checked against a decimal reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        areset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] bin_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [39:0] bcd_out;
    logic        overflow;

    logic        in_valid_s = 1'b0;
    logic        in_ready_s;
    logic [9:0]  bin_in_s = '0;
    logic        out_valid_s;
    logic        out_ready_s = 1'b1;
    logic [11:0] bcd_out_s;
    logic        overflow_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) dut (
        .clk(clk), .areset(areset),
        .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .overflow(overflow)
    );

    bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) dut_s (
        .clk(clk), .areset(areset),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .bin_in(bin_in_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .bcd_out(bcd_out_s), .overflow(overflow_s)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: decimal digits of v mod 10^digits, packed 4 bits each.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits);
        logic [63:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return v >= p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion on the default instance; stall = cycles out_ready held low in DONE.
    task automatic convert(input logic [31:0] v, input int stall, input string tag);
        int n;
        logic saw_ready;
        logic [39:0] held;
        logic held_ovf;
        chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        bin_in    = v;
        tick();
        in_valid  = 1'b0;
        bin_in    = $urandom;
        n = 0;
        saw_ready = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) saw_ready = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_in_ready_busy"}, saw_ready, 1'b0);
        chk({tag, "_bcd"}, 64'(bcd_out), ref_bcd(64'(v), 10));
        chk({tag, "_ovf"}, overflow, ref_ovf(64'(v), 10));
        if (stall > 0) begin
            held = bcd_out;
            held_ovf = overflow;
            for (int i = 0; i < stall; i++) begin
                in_valid = (i == stall / 2);
                bin_in   = 32'd77;
                tick();
            end
            in_valid = 1'b0;
            chk({tag, "_stall_valid"}, out_valid, 1'b1);
            chk({tag, "_stall_ready"}, in_ready, 1'b0);
            chk({tag, "_stall_bcd"}, 64'(bcd_out), 64'(held));
            chk({tag, "_stall_ovf"}, held_ovf, overflow);
            out_ready = 1'b1;
        end
        tick();
        chk({tag, "_back_idle"}, in_ready, 1'b1);
        chk({tag, "_valid_drop"}, out_valid, 1'b0);
    endtask

    task automatic convert_s(input logic [9:0] v, input string tag);
        int n;
        in_valid_s = 1'b1;
        bin_in_s   = v;
        tick();
        in_valid_s = 1'b0;
        n = 0;
        while (!out_valid_s && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd10);
        chk({tag, "_bcd"}, 64'(bcd_out_s), ref_bcd(64'(v), 3));
        chk({tag, "_ovf"}, overflow_s, ref_ovf(64'(v), 3));
        tick();
        chk({tag, "_idle"}, in_ready_s, 1'b1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_bcd", 64'(bcd_out), 64'd0);
        chk("rst_ovf", overflow, 1'b0);
        areset = 1'b0;
        tick();

        convert(32'hFFFF_FFFF, 0, "max");
        chk("max_const", 64'(ref_bcd(64'hFFFF_FFFF, 10)), 64'h42_9496_7295);
        convert(32'd0, 0, "zero");
        convert(32'd9, 0, "nine");
        convert(32'd10, 0, "ten");
        convert(32'd12345678, 20, "stall");

        convert_s(10'd1023, "s1023");
        convert_s(10'd999, "s999");
        convert_s(10'd0, "s0");

        // Abort mid-conversion with an asynchronous reset pulse.
        in_valid = 1'b1;
        bin_in   = 32'd12345678;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        areset = 1'b1;
        #2;
        areset = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_bcd", 64'(bcd_out), 64'd0);
        chk("abort_ovf", overflow, 1'b0);
        tick();
        tick();
        chk("abort_still_idle", out_valid, 1'b0);
        convert(32'd12345678, 0, "after_abort");

        for (int k = 0; k < 25; k++) begin
            convert($urandom_range(32'hFFFF_FFFF, 1000), int'($urandom_range(6, 0)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
